store_buffer: RTL and testbench
===============================

Name: store_buffer

Overview:
- Small in-order store FIFO between the EX/MEM pipeline register and the byte-addressed 16-bit data memory.
- Absorbs stores (byte or word) so the pipeline does not wait on the memory write port. Drains one store per cycle into the memory when the port is not needed by a load.
- Stalls any load whose bytes overlap a pending store, so loads never return stale data.

Parameters:
- DEPTH, 4, number of store entries (power of two, ≥2)
- ADDR_W, 16, byte address width
- DATA_W, 16, store data width (low byte used for byte stores)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous active-low reset
- st_valid  input  1  pipeline presents a store this cycle
- st_addr  input  ADDR_W  store byte address
- st_data  input  DATA_W  store data; [7:0] only when st_byte=1
- st_byte  input  1  1 = byte store, 0 = word store (little-endian: addr←[7:0], addr+1←[15:8])
- st_ready  output  1  buffer can accept a store (not full)
- ld_req  input  1  pipeline requests a load this cycle
- ld_addr  input  ADDR_W  load byte address (load always covers ld_addr and ld_addr+1)
- ld_stall  output  1  load blocked by overlap with a pending store
- mem_read  output  1  to memory memRead
- mem_write  output  1  to memory memWrite
- mem_addr  output  ADDR_W  to memory addr
- mem_wdata  output  DATA_W  to memory wrData
- mem_sbyte  output  1  to memory sByte
- count  output  $clog2(DEPTH)+1  valid entries
- empty  output  1  count==0
- full  output  1  count==DEPTH

Behaviour:
- Reset (rst=0, asynchronous): head=tail=0, count=0, all entry valid bits cleared. Outputs while held in reset: empty=1, full=0, st_ready=1, mem_write=0, mem_read=0. Reset mid-drain discards all pending stores; no partial write is issued after reset.
- Enqueue: on a rising edge with st_valid & st_ready, write {addr, data, byte} at tail; tail advances modulo DEPTH. st_ready = ~full.
  - No enqueue when full, even if a pop occurs that cycle. st_valid while full is dropped; the pipeline must hold.
- Load arbitration (combinational, same cycle):
  - Overlap exists for a valid entry with address s when the load bytes {L, L+1} intersect the store bytes ({s} for byte, {s, s+1} for word). All +1 arithmetic wraps mod 2^ADDR_W (0xFFFF+1 = 0x0000).
  - ld_stall = ld_req & (overlap with any valid entry).
  - mem_read = ld_req & ~ld_stall. When mem_read=1, mem_addr = ld_addr.
- Drain:
  - drain = ~empty & ~mem_read.
  - When drain=1: mem_write=1, and mem_addr/mem_wdata/mem_sbyte come from the head entry. The head pops on the same rising edge that the memory captures the write; head advances modulo DEPTH.
  - Otherwise mem_write=0, mem_wdata=0, mem_sbyte=0.
  - mem_addr = 0 when neither a read nor a write is in progress.
- Stall resolution: a stalled load makes mem_read=0, so drain proceeds and the stall clears within ≤count cycles. Latency from store acceptance to memory write is ≥1 cycle (never the same edge).
- Count: next count = count + enq − pop. Simultaneous enq and pop leaves count unchanged.
- Ordering: stores reach memory strictly in acceptance order.
- Protocol: the pipeline never asserts st_valid and ld_req in the same cycle. The bench checks this with an assertion; the RTL need not handle the case.

Test Plan:
- Reset then idle → empty=1, count=0, st_ready=1, mem_write=0, mem_read=0. Assert rst=0 mid-operation → same values immediately, before the next clk edge.
- Word store addr 0x0004 data 0x5678, then no loads → one cycle later mem_write=1, mem_addr=0x0004, mem_wdata=0x5678, mem_sbyte=0 for exactly one cycle; count returns to 0.
- Four stores (0x10, 0x12, 0x14, 0x16) back-to-back with ld_req held 1 at non-overlapping 0x0100 → full=1, st_ready=0 after the 4th. A 5th st_valid is not accepted. The load is granted every cycle (mem_read=1, mem_addr=0x0100) and nothing drains. Drop ld_req → 4 writes in order on 4 consecutive cycles.
- Byte store addr 0x0009 data 0x00BE, then load 0x0008 → ld_stall=1, mem_read=0, write to 0x0009 with mem_sbyte=1 issues. Next cycle ld_stall=0, mem_read=1. Same byte store with load 0x000A → ld_stall=0 and the load is granted immediately.
- Wrap case: word store at 0xFFFF, load at 0x0000 → ld_stall=1 (overlap at byte 0x0000). Load at 0x0001 → no stall.
- Pointer wrap: 10 stores interleaved with drains (DEPTH=4) → all 10 writes appear in order with correct addr/data; count never exceeds 4.

Source files
------------

// File: rtl/store_buffer.sv
// In-order store FIFO between EX/MEM and a byte-addressed 16-bit data memory.
// Loads take priority on the memory port and stall while they overlap a pending store.
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       st_valid,
  input  logic [ADDR_W-1:0]          st_addr,
  input  logic [DATA_W-1:0]          st_data,
  input  logic                       st_byte,
  output logic                       st_ready,
  input  logic                       ld_req,
  input  logic [ADDR_W-1:0]          ld_addr,
  output logic                       ld_stall,
  output logic                       mem_read,
  output logic                       mem_write,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  output logic                       mem_sbyte,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_q  [DEPTH];
  logic [DATA_W-1:0] data_q  [DEPTH];
  logic              byte_q  [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [PTR_W-1:0]  head, tail;
  logic [CNT_W-1:0]  cnt;

  logic enq, pop, hit, drain;

  // Byte-range intersection of a 2-byte load with a 1- or 2-byte store; +1 wraps.
  function automatic logic overlaps(input logic [ADDR_W-1:0] l,
                                    input logic [ADDR_W-1:0] s,
                                    input logic              s_byte);
    logic [ADDR_W-1:0] l1, s1;
    l1 = l + 1'b1;
    s1 = s + 1'b1;
    overlaps = (l == s) || (l1 == s) || (!s_byte && (l == s1));
  endfunction

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && overlaps(ld_addr, addr_q[i], byte_q[i]))
        hit = 1'b1;
    end
  end

  assign count    = cnt;
  assign empty    = (cnt == '0);
  assign full     = (cnt == CNT_W'(DEPTH));
  assign st_ready = ~full;
  assign enq      = st_valid & ~full;

  // Reset gating keeps the read strobe low while the buffer is held in reset.
  assign ld_stall = ld_req & hit;
  assign mem_read = rst & ld_req & ~hit;
  assign drain    = ~empty & ~mem_read;
  assign pop      = drain;

  always_comb begin
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_sbyte = 1'b0;
    if (mem_read) begin
      mem_addr = ld_addr;
    end else if (drain) begin
      mem_write = 1'b1;
      mem_addr  = addr_q[head];
      mem_wdata = data_q[head];
      mem_sbyte = byte_q[head];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head    <= '0;
      tail    <= '0;
      cnt     <= '0;
      valid_q <= '0;
    end else begin
      if (enq) begin
        valid_q[tail] <= 1'b1;
        tail          <= tail + 1'b1;
      end
      if (pop) begin
        valid_q[head] <= 1'b0;
        head          <= head + 1'b1;
      end
      cnt <= cnt + CNT_W'(enq) - CNT_W'(pop);
    end
  end

  // Entry payload is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[tail] <= st_addr;
      data_q[tail] <= st_data;
      byte_q[tail] <= st_byte;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: hand-computed expectations checked with immediate assertions.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic [15:0] st_addr;
  logic [15:0] st_data;
  logic        st_byte;
  logic        st_ready;
  logic        ld_req;
  logic [15:0] ld_addr;
  logic        ld_stall;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_sbyte;
  logic [2:0]  count;
  logic        empty;
  logic        full;

  int checks = 0;
  int errors = 0;
  logic allow_both = 1'b0;

  store_buffer #(.DEPTH(4), .ADDR_W(16), .DATA_W(16)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_byte(st_byte),
    .st_ready(st_ready),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_stall(ld_stall),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_sbyte(mem_sbyte),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst && !allow_both)
      assert (!(st_valid && ld_req)) else begin
        errors++;
        $error("FAIL protocol: st_valid and ld_req both high");
      end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [15:0] a, input logic [15:0] d, input logic b);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_byte  = b;
  endtask

  task automatic idle_in();
    st_valid = 1'b0;
    st_addr  = '0;
    st_data  = '0;
    st_byte  = 1'b0;
    ld_req   = 1'b0;
    ld_addr  = '0;
  endtask

  task automatic chk_write(input string tag, input logic [15:0] a,
                           input logic [15:0] d, input logic b);
    chk({tag, "_wr"},    mem_write, 1'b1);
    chk({tag, "_addr"},  mem_addr,  a);
    chk({tag, "_wdata"}, mem_wdata, d);
    chk({tag, "_sbyte"}, mem_sbyte, b);
  endtask

  initial begin
    rst = 1'b0;
    idle_in();
    #3;
    chk("rst_empty",  empty,     1'b1);
    chk("rst_count",  count,     3'd0);
    chk("rst_ready",  st_ready,  1'b1);
    chk("rst_full",   full,      1'b0);
    chk("rst_mwrite", mem_write, 1'b0);
    chk("rst_mread",  mem_read,  1'b0);
    #9 rst = 1'b1;
    step();

    // Single word store drains one cycle later for exactly one cycle.
    store(16'h0004, 16'h5678, 1'b0);
    #1 chk("w1_nowr_same_edge", mem_write, 1'b0);
    step();
    idle_in();
    #1;
    chk("w1_count", count, 3'd1);
    chk_write("w1", 16'h0004, 16'h5678, 1'b0);
    step();
    chk("w1_done_wr",    mem_write, 1'b0);
    chk("w1_done_addr",  mem_addr,  16'h0000);
    chk("w1_done_wdata", mem_wdata, 16'h0000);
    chk("w1_done_count", count,     3'd0);

    // Fill to full while a non-overlapping load holds the port.
    allow_both = 1'b1;
    ld_req  = 1'b1;
    ld_addr = 16'h0100;
    store(16'h0010, 16'hA010, 1'b0);
    #1;
    chk("fill_mread0", mem_read,  1'b1);
    chk("fill_maddr0", mem_addr,  16'h0100);
    chk("fill_mwr0",   mem_write, 1'b0);
    step();
    store(16'h0012, 16'hA012, 1'b0);
    #1 chk("fill_cnt1", count, 3'd1);
    step();
    store(16'h0014, 16'hA014, 1'b0);
    #1 chk("fill_cnt2", count, 3'd2);
    step();
    store(16'h0016, 16'hA016, 1'b0);
    #1;
    chk("fill_cnt3",  count,     3'd3);
    chk("fill_mwr3",  mem_write, 1'b0);
    chk("fill_mrd3",  mem_read,  1'b1);
    step();
    store(16'h0018, 16'hA018, 1'b0);
    #1;
    chk("full_full",  full,      1'b1);
    chk("full_ready", st_ready,  1'b0);
    chk("full_cnt",   count,     3'd4);
    chk("full_mread", mem_read,  1'b1);
    chk("full_maddr", mem_addr,  16'h0100);
    chk("full_mwr",   mem_write, 1'b0);
    step();
    chk("fifth_dropped_cnt", count, 3'd4);
    idle_in();
    allow_both = 1'b0;
    #1;
    chk_write("dr0", 16'h0010, 16'hA010, 1'b0);
    step();
    chk_write("dr1", 16'h0012, 16'hA012, 1'b0);
    chk("dr1_cnt", count, 3'd3);
    step();
    chk_write("dr2", 16'h0014, 16'hA014, 1'b0);
    step();
    chk_write("dr3", 16'h0016, 16'hA016, 1'b0);
    chk("dr3_cnt", count, 3'd1);
    step();
    chk("dr_done_wr",  mem_write, 1'b0);
    chk("dr_done_cnt", count,     3'd0);

    // Byte store at 0x0009 vs load at 0x0008 (overlap) then 0x000A (no overlap).
    store(16'h0009, 16'h00BE, 1'b1);
    step();
    idle_in();
    ld_req  = 1'b1;
    ld_addr = 16'h0008;
    #1;
    chk("bs_stall", ld_stall, 1'b1);
    chk("bs_mread", mem_read, 1'b0);
    chk_write("bs", 16'h0009, 16'h00BE, 1'b1);
    step();
    chk("bs_stall_clr", ld_stall, 1'b0);
    chk("bs_mread2",    mem_read, 1'b1);
    chk("bs_maddr2",    mem_addr, 16'h0008);
    ld_req = 1'b0;
    store(16'h0009, 16'h00BE, 1'b1);
    step();
    idle_in();
    ld_req  = 1'b1;
    ld_addr = 16'h000A;
    #1;
    chk("bs2_stall", ld_stall,  1'b0);
    chk("bs2_mread", mem_read,  1'b1);
    chk("bs2_maddr", mem_addr,  16'h000A);
    chk("bs2_mwr",   mem_write, 1'b0);
    step();
    idle_in();
    #1 chk_write("bs2", 16'h0009, 16'h00BE, 1'b1);
    step();

    // Address wrap: word store at 0xFFFF covers 0xFFFF and 0x0000.
    store(16'hFFFF, 16'h1234, 1'b0);
    step();
    idle_in();
    ld_req  = 1'b1;
    ld_addr = 16'h0001;
    #1;
    chk("wrap_l1_stall", ld_stall, 1'b0);
    chk("wrap_l1_mread", mem_read, 1'b1);
    step();
    ld_addr = 16'h0000;
    #1;
    chk("wrap_l0_stall", ld_stall, 1'b1);
    chk_write("wrap", 16'hFFFF, 16'h1234, 1'b0);
    step();
    chk("wrap_l0_clr",   ld_stall, 1'b0);
    chk("wrap_l0_mread", mem_read, 1'b1);
    chk("wrap_l0_maddr", mem_addr, 16'h0000);
    idle_in();
    step();

    // Asynchronous reset mid-drain discards pending stores immediately.
    allow_both = 1'b1;
    ld_req  = 1'b1;
    ld_addr = 16'h0300;
    store(16'h0020, 16'hB020, 1'b0);
    step();
    store(16'h0022, 16'hB022, 1'b0);
    step();
    idle_in();
    allow_both = 1'b0;
    #1 chk_write("pre_rst", 16'h0020, 16'hB020, 1'b0);
    rst = 1'b0;
    ld_req = 1'b1;
    #1;
    chk("mid_rst_empty", empty,     1'b1);
    chk("mid_rst_count", count,     3'd0);
    chk("mid_rst_ready", st_ready,  1'b1);
    chk("mid_rst_full",  full,      1'b0);
    chk("mid_rst_mwr",   mem_write, 1'b0);
    chk("mid_rst_mrd",   mem_read,  1'b0);
    ld_req = 1'b0;
    step();
    rst = 1'b1;
    step();
    chk("post_rst_mwr", mem_write, 1'b0);
    chk("post_rst_cnt", count,     3'd0);

    // Ten back-to-back stores wrap both pointers; each drains the following cycle.
    for (int i = 0; i < 10; i++) begin
      store(16'h0200 + 16'(2 * i), 16'hC000 + 16'(i), 1'b0);
      #1;
      if (i > 0)
        chk_write($sformatf("ptr%0d", i - 1), 16'h0200 + 16'(2 * (i - 1)),
                  16'hC000 + 16'(i - 1), 1'b0);
      step();
      chk($sformatf("ptr%0d_cnt", i), count, 3'd1);
    end
    idle_in();
    #1 chk_write("ptr9", 16'h0212, 16'hC009, 1'b0);
    step();
    chk("ptr_done_cnt",   count,     3'd0);
    chk("ptr_done_empty", empty,     1'b1);
    chk("ptr_done_wr",    mem_write, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
